mii_mac_tx: RTL and testbench
=============================

// Module: mii_mac_tx
// PURPOSE
//  MII transmit MAC, the egress counterpart of the receive path. Accepts a byte stream (DA..payload, no preamble/FCS) on a valid/ready/last interface.
//  Emits preamble+SFD, data, zero padding to minimum length, CRC-32 FCS and inter-frame gap as 4-bit nibbles on TXD/TXEN, low nibble first.
//  Sits between the TX frame builder/FIFO and the PHY; runs entirely in the ETH_TXCK domain.
// PARAMETERS
//  MIN_LEN   60    min bytes before FCS; shorter frames padded with 0x00
//  MAX_LEN   1514  max bytes before FCS; exceeding byte aborts frame (as underrun)
//  IFG_BYTES 12    inter-frame gap in bytes (2*IFG_BYTES clocks)
// PORTS
//  tx_clk      in  1  MII TX clock (25 MHz at 100M); sole clock
//  rst_n       in  1  synchronous, active-low reset
//  data_in     in  8  frame byte
//  in_valid    in  1  data_in valid
//  in_last     in  1  data_in is last byte of frame
//  in_ready    out 1  byte accepted when in_valid&&in_ready
//  tx_data     out 4  MII TXD, registered
//  tx_en       out 1  MII TXEN, registered
//  tx_er       out 1  MII TXER, registered
//  frame_sent  out 1  1-clk pulse: frame completed with good FCS
//  tx_abort    out 1  1-clk pulse: frame aborted (underrun/oversize)
// BEHAVIOUR
//  - Reset: state=IDLE; tx_data=0, tx_en=0, tx_er=0, in_ready=0, frame_sent=0, tx_abort=0; CRC=32'hFFFFFFFF; counters 0.
//  - Reset mid-frame: outputs go to reset values next edge; partial frame abandoned, upstream not drained.
//  - One nibble per clock; each byte = 2 clocks, [3:0] then [7:4].
//  - States: IDLE -> PRE -> DATA -> PAD -> FCS -> IFG -> IDLE; DRAIN on abort.
//  - IDLE: in_valid=1 -> PRE next clock; byte not consumed. in_ready=0.
//  - PRE: 16 clocks, tx_en=1: 15 nibbles 0x5 then 0xD (55x7,D5). in_ready=1 on the SFD clock fetches byte 0.
//  - DATA: fetched byte output over next 2 clocks. in_ready=1 (combinational from state/nibble phase) on second nibble of each byte, unless current byte was in_last.
//    - Handshake with in_valid=0 while in_ready=1: underrun -> abort.
//  - Byte counter is 11 bits, counts bytes sent before FCS.
//    - After in_last byte: PAD if count<MIN_LEN, else FCS.
//    - Fetch of byte MAX_LEN+1 (in_last not yet seen): abort.
//  - PAD: 0x00 bytes until count==MIN_LEN, then FCS.
//  - CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF. Updated per transmitted nibble over DATA+PAD only (not preamble).
//  - FCS: ~CRC sent LSB first as 8 nibbles, CRC[3:0] first, tx_en=1. frame_sent pulses on last FCS nibble clock.
//  - IFG: tx_en=0 for 2*IFG_BYTES clocks; in_ready=0; then IDLE. CRC re-init on leaving IFG.
//  - Abort: tx_en and tx_er both high for 2 clocks on the offending slot, then tx_en=0. tx_abort pulses once.
//    - Then DRAIN: in_ready=1, discard bytes through in_last (if not already consumed), then IFG.
//  - tx_en low clock count between frames is never < 2*IFG_BYTES.
//  - Oversize while draining is ignored.
//  - in_last on a byte with in_valid=0 is ignored.
// TESTING
//  - 14-byte frame, valid held: tx_en high 2*(8+60+4)=144 clocks.
//    - 16 preamble nibbles end 0xD; bytes 15..60 are 0x00.
//    - Reflected CRC over data+pad+FCS (init FFFFFFFF, no final xor) = 0xDEBB20E3; one frame_sent.
//  - 100-byte frame: no padding, tx_en high 224 clocks; FCS matches bench CRC model.
//  - Two frames presented back to back: tx_en low exactly 24 clocks between them; in_ready low during IFG.
//  - in_valid dropped at byte 30 of 100-byte frame: tx_er=1 for 2 clocks, tx_en falls, tx_abort=1 once.
//    - Remaining 70 bytes drained; no frame_sent; next frame sent correctly.
//  - 1600-byte frame with in_last on byte 1600: abort at byte 1515 fetch, drain to in_last, IFG, IDLE.
//  - rst_n low for 1 clock during FCS: next edge tx_en=0, tx_er=0, in_ready=0; new frame after reset gives correct FCS.

Source files
------------

// File: rtl/mii_mac_tx.sv
// MII transmit MAC: preamble/SFD, data, zero pad, CRC-32 FCS and IFG.
// Byte stream in on valid/ready/last, nibbles out low-first on TXD/TXEN.
module mii_mac_tx #(
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_sent,
    output logic       tx_abort
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAD   = 3'd3;
    localparam logic [2:0] S_FCS   = 3'd4;
    localparam logic [2:0] S_IFG   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
    localparam logic [2:0] S_DRAIN = 3'd7;

    localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);
    localparam logic [10:0] IFG_END = 11'(2 * IFG_BYTES - 1);
    localparam logic [31:0] POLY    = 32'hEDB88320;

    // state holds the slot currently visible on the MII pins;
    // the *_nx values describe the slot shown after the next edge.
    logic [2:0]  state, state_nx;
    logic [10:0] sub, sub_nx;
    logic [10:0] bytes, bytes_nx;
    logic        phase, phase_nx;
    logic [7:0]  cur, cur_nx;
    logic        last, last_nx;
    logic [31:0] crc, crc_nx;
    logic [31:0] fcs;
    logic [2:0]  fidx;
    logic [3:0]  nib_nx;
    logic        en_nx, er_nx, sent_nx, abort_nx, crc_upd;

    function automatic logic [31:0] crc_nib(input logic [31:0] c,
                                            input logic [3:0]  d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs  = ~crc;
    assign fidx = sub[2:0] + 3'd1;

    // Upstream is asked for a byte on the SFD slot, on the high nibble
    // of every non-final byte, and continuously while draining.
    always_comb begin
        unique case (state)
            S_PRE:   in_ready = (sub == 11'd15);
            S_DATA:  in_ready = phase && !last;
            S_DRAIN: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Sequencing and the next nibble to drive on the MII pins.
    always_comb begin
        state_nx = state;
        sub_nx   = sub;
        bytes_nx = bytes;
        phase_nx = phase;
        cur_nx   = cur;
        last_nx  = last;
        crc_nx   = crc;
        nib_nx   = 4'h0;
        en_nx    = 1'b0;
        er_nx    = 1'b0;
        sent_nx  = 1'b0;
        abort_nx = 1'b0;
        crc_upd  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_PRE;
                    sub_nx   = 11'd0;
                    nib_nx   = 4'h5;
                    en_nx    = 1'b1;
                end
            end
            S_PRE: begin
                if (sub != 11'd15) begin
                    sub_nx = sub + 11'd1;
                    nib_nx = (sub == 11'd14) ? 4'hD : 4'h5;
                    en_nx  = 1'b1;
                end else if (in_valid) begin
                    state_nx = S_DATA;
                    phase_nx = 1'b0;
                    cur_nx   = data_in;
                    last_nx  = in_last;
                    bytes_nx = 11'd1;
                    nib_nx   = data_in[3:0];
                    en_nx    = 1'b1;
                    crc_upd  = 1'b1;
                end else begin
                    state_nx = S_ERR;
                    sub_nx   = 11'd0;
                    last_nx  = 1'b0;
                    en_nx    = 1'b1;
                    er_nx    = 1'b1;
                    abort_nx = 1'b1;
                end
            end
            S_DATA: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                    nib_nx   = cur[7:4];
                    en_nx    = 1'b1;
                    crc_upd  = 1'b1;
                end else if (last) begin
                    if (bytes < MIN_CNT) begin
                        state_nx = S_PAD;
                        phase_nx = 1'b0;
                        bytes_nx = bytes + 11'd1;
                        en_nx    = 1'b1;
                        crc_upd  = 1'b1;
                    end else begin
                        state_nx = S_FCS;
                        sub_nx   = 11'd0;
                        nib_nx   = fcs[3:0];
                        en_nx    = 1'b1;
                    end
                end else if (!in_valid || bytes == MAX_CNT) begin
                    state_nx = S_ERR;
                    sub_nx   = 11'd0;
                    last_nx  = in_valid && in_last;
                    en_nx    = 1'b1;
                    er_nx    = 1'b1;
                    abort_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    cur_nx   = data_in;
                    last_nx  = in_last;
                    bytes_nx = bytes + 11'd1;
                    nib_nx   = data_in[3:0];
                    en_nx    = 1'b1;
                    crc_upd  = 1'b1;
                end
            end
            S_PAD: begin
                if (!phase || bytes < MIN_CNT) begin
                    phase_nx = !phase;
                    if (phase) begin
                        bytes_nx = bytes + 11'd1;
                    end
                    en_nx   = 1'b1;
                    crc_upd = 1'b1;
                end else begin
                    state_nx = S_FCS;
                    sub_nx   = 11'd0;
                    nib_nx   = fcs[3:0];
                    en_nx    = 1'b1;
                end
            end
            S_FCS: begin
                if (sub != 11'd7) begin
                    sub_nx  = sub + 11'd1;
                    nib_nx  = fcs[{fidx, 2'b00} +: 4];
                    en_nx   = 1'b1;
                    sent_nx = (sub == 11'd6);
                end else begin
                    state_nx = S_IFG;
                    sub_nx   = 11'd0;
                end
            end
            S_IFG: begin
                if (sub != IFG_END) begin
                    sub_nx = sub + 11'd1;
                end else begin
                    crc_nx   = 32'hFFFFFFFF;
                    bytes_nx = 11'd0;
                    sub_nx   = 11'd0;
                    if (in_valid) begin
                        state_nx = S_PRE;
                        nib_nx   = 4'h5;
                        en_nx    = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                if (sub == 11'd0) begin
                    sub_nx = 11'd1;
                    en_nx  = 1'b1;
                    er_nx  = 1'b1;
                end else begin
                    state_nx = last ? S_IFG : S_DRAIN;
                    sub_nx   = 11'd0;
                end
            end
            S_DRAIN: begin
                if (in_valid && in_last) begin
                    state_nx = S_IFG;
                    sub_nx   = 11'd0;
                end
            end
        endcase
        if (crc_upd) begin
            crc_nx = crc_nib(crc, nib_nx);
        end
    end

    // Register state and all MII/status outputs.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sub        <= 11'd0;
            bytes      <= 11'd0;
            phase      <= 1'b0;
            cur        <= 8'h00;
            last       <= 1'b0;
            crc        <= 32'hFFFFFFFF;
            tx_data    <= 4'h0;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_sent <= 1'b0;
            tx_abort   <= 1'b0;
        end else begin
            state      <= state_nx;
            sub        <= sub_nx;
            bytes      <= bytes_nx;
            phase      <= phase_nx;
            cur        <= cur_nx;
            last       <= last_nx;
            crc        <= crc_nx;
            tx_data    <= nib_nx;
            tx_en      <= en_nx;
            tx_er      <= er_nx;
            frame_sent <= sent_nx;
            tx_abort   <= abort_nx;
        end
    end

endmodule

// File: tb/tb_mii_mac_tx.sv
// Testbench for mii_mac_tx: random frames against a frame-level model,
// scoreboarded per MII burst by an independent monitor.
module tb_mii_mac_tx;

    typedef logic [7:0] byte_q_t[$];

    logic       tx_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] tx_data;
    logic       tx_en, tx_er, frame_sent, tx_abort;

    int errors = 0;
    int checks = 0;

    mii_mac_tx dut (
        .tx_clk(tx_clk), .rst_n(rst_n), .data_in(data_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
        .frame_sent(frame_sent), .tx_abort(tx_abort)
    );

    always #20 tx_clk = ~tx_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] crc_raw(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic byte_q_t rand_frame(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Expected bursts: nibble stream {er, data}, length, pulse counts.
    logic [4:0] exp_nib[$];
    int exp_len[$];
    int exp_sent[$];
    int exp_abort[$];

    task automatic expect_frame(input byte_q_t b, input int cut);
        byte_q_t p;
        logic [7:0] v;
        logic [31:0] f;
        for (int i = 0; i < 15; i++) exp_nib.push_back(5'h05);
        exp_nib.push_back(5'h0D);
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) begin
                v = b[i];
                exp_nib.push_back({1'b0, v[3:0]});
                exp_nib.push_back({1'b0, v[7:4]});
            end
            exp_nib.push_back(5'h10);
            exp_nib.push_back(5'h10);
            exp_len.push_back(16 + 2 * cut + 2);
            exp_sent.push_back(0);
            exp_abort.push_back(1);
        end else begin
            p = b;
            while (p.size() < 60) p.push_back(8'h00);
            f = ~crc_raw(p);
            foreach (p[i]) begin
                v = p[i];
                exp_nib.push_back({1'b0, v[3:0]});
                exp_nib.push_back({1'b0, v[7:4]});
            end
            for (int k = 0; k < 8; k++) exp_nib.push_back({1'b0, f[4*k +: 4]});
            exp_len.push_back(16 + 2 * p.size() + 8);
            exp_sent.push_back(1);
            exp_abort.push_back(0);
        end
    endtask

    task automatic drive(input byte_q_t b, input int drop_at);
        int i = 0;
        int guard = 0;
        bit hs;
        bit dropped = 0;
        while (i < b.size()) begin
            if (i == drop_at && !dropped) begin
                in_valid = 1'b0;
                in_last = 1'b1;
                data_in = 8'hA5;
                hs = 1'b0;
                while (!hs && guard < 300) begin
                    @(negedge tx_clk); hs = in_ready;
                    @(posedge tx_clk); #1; guard++;
                end
                repeat (6) @(posedge tx_clk);
                #1;
                dropped = 1;
            end
            data_in = b[i];
            in_last = (i == b.size() - 1);
            in_valid = 1'b1;
            @(negedge tx_clk); hs = in_ready;
            @(posedge tx_clk); #1;
            if (hs) i++;
            guard++;
            if (guard > 5000) begin
                timeout("drive");
                break;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Monitor: capture each tx_en burst and score it at its end.
    logic [4:0] cap[$];
    logic [4:0] last_burst[$];
    logic [4:0] mon_e;
    int mon_len;
    int n_sent = 0, n_abort = 0, gap = 0, last_gap = 0, bursts = 0;
    int cur_len = 0;
    bit in_burst = 0, seen = 0, skip_burst = 0, skip_gap = 0;
    bit gap_rdy = 0, last_gap_rdy = 0;

    always @(negedge tx_clk) begin
        if (rst_n && tx_en) begin
            if (!in_burst) begin
                if (seen && !skip_gap) begin
                    checks++;
                    if (gap < 24) begin
                        errors++;
                        $display("FAIL ifg_min: got=%0d want>=24", gap);
                    end
                end
                last_gap = gap;
                last_gap_rdy = gap_rdy;
                skip_gap = 0;
                in_burst = 1;
                cap.delete();
                n_sent = 0;
                n_abort = 0;
            end
            cap.push_back({tx_er, tx_data});
            n_sent += int'(frame_sent);
            n_abort += int'(tx_abort);
            cur_len = cap.size();
        end else begin
            if (frame_sent || tx_abort) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: got=%b%b want=00",
                         frame_sent, tx_abort);
            end
            if (in_burst) begin
                in_burst = 0;
                seen = 1;
                gap = 0;
                gap_rdy = 0;
                bursts++;
                if (skip_burst) begin
                    skip_burst = 0;
                    skip_gap = 1;
                end else if (exp_len.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: got=%0d want=none",
                             cap.size());
                end else begin
                    mon_len = exp_len.pop_front();
                    chk("burst_len", cap.size(), mon_len);
                    for (int k = 0; k < mon_len; k++) begin
                        mon_e = exp_nib.pop_front();
                        if (k < cap.size()) begin
                            if (mon_e[4]) chk("err_slot", cap[k][4], 1);
                            else chk($sformatf("nib%0d", k), cap[k], mon_e);
                        end
                    end
                    chk("frame_sent", n_sent, exp_sent.pop_front());
                    chk("tx_abort", n_abort, exp_abort.pop_front());
                    last_burst = cap;
                end
            end
            gap++;
            gap_rdy |= in_ready;
        end
    end

    task automatic wait_idle();
        int g = 0;
        while ((exp_len.size() != 0 || in_burst || gap < 30) && g < 20000) begin
            @(negedge tx_clk); #1; g++;
        end
        if (g >= 20000) timeout("wait_idle");
    endtask

    initial begin
        byte_q_t f, f2, res;
        logic [31:0] r;
        int g;

        repeat (3) @(posedge tx_clk);
        #1;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_er", tx_er, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sent", frame_sent, 0);
        chk("rst_abort", tx_abort, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge tx_clk);
        #1;

        f = rand_frame(14);
        expect_frame(f, -1);
        drive(f, -1);
        wait_idle();
        chk("len14", last_burst.size(), 144);
        res.delete();
        for (int k = 16; k + 1 < last_burst.size(); k += 2)
            res.push_back({last_burst[k+1][3:0], last_burst[k][3:0]});
        r = crc_raw(res);
        chk("residue", r, 32'hDEBB20E3);

        f = rand_frame(100);
        expect_frame(f, -1);
        drive(f, -1);
        wait_idle();
        chk("len100", last_burst.size(), 224);

        f = rand_frame(20);
        f2 = rand_frame(70);
        expect_frame(f, -1);
        drive(f, -1);
        expect_frame(f2, -1);
        drive(f2, -1);
        wait_idle();
        chk("b2b_gap", last_gap, 24);
        chk("b2b_ready_in_ifg", last_gap_rdy, 0);

        f = rand_frame(100);
        expect_frame(f, 30);
        drive(f, 30);
        f = rand_frame(40);
        expect_frame(f, -1);
        drive(f, -1);
        wait_idle();

        foreach (res[i]) res[i] = 8'h00;
        for (int n = 0; n < 5; n++) begin
            int len;
            len = (n == 0) ? 1 : (n == 1) ? 59 : (n == 2) ? 60 :
                  (n == 3) ? 61 : 1514;
            f = rand_frame(len);
            expect_frame(f, -1);
            drive(f, -1);
            wait_idle();
        end

        f = rand_frame(1600);
        expect_frame(f, 1514);
        drive(f, -1);
        f = rand_frame(1515);
        expect_frame(f, 1514);
        drive(f, -1);
        f = rand_frame(33);
        expect_frame(f, -1);
        drive(f, -1);
        wait_idle();

        for (int n = 0; n < 8; n++) begin
            f = rand_frame($urandom_range(1, 150));
            expect_frame(f, -1);
            drive(f, -1);
            if ($urandom_range(0, 1) == 1) wait_idle();
            else repeat ($urandom_range(0, 40)) @(posedge tx_clk);
            #1;
        end
        wait_idle();

        skip_burst = 1;
        f = rand_frame(14);
        drive(f, -1);
        g = 0;
        while (cur_len < 138 && g < 1000) begin
            @(negedge tx_clk); #1; g++;
        end
        if (g >= 1000) timeout("reach_fcs");
        #2 rst_n = 1'b0;
        @(posedge tx_clk); #1;
        chk("fcs_rst_tx_en", tx_en, 0);
        chk("fcs_rst_tx_er", tx_er, 0);
        chk("fcs_rst_in_ready", in_ready, 0);
        @(negedge tx_clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge tx_clk);
        #1;
        f = rand_frame(64);
        expect_frame(f, -1);
        drive(f, -1);
        wait_idle();

        chk("leftover", exp_len.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
